// File: rtl/etcpu_pipe_ctrl.sv
// Pipeline register bank for etcpu cores: per-stage stall, bubble collapse, NOP fill, partial flush, perf counters.
// Latency: an accepted instruction is presented on out_vld STAGES-1 edges later; one instruction per cycle.
// Backpressure: stalls and out_rdy=0 propagate upstream only through valid regs; in_rdy is combinational.
module etcpu_pipe_ctrl #(
    parameter int unsigned       STAGES   = 4,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DAT_W    = 96,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [INST_W-1:0]             in_inst,
    input  logic [DAT_W-1:0]              in_dat,
    output logic                          in_rdy,
    input  logic [STAGES-1:0]             stg_stall,
    input  logic [STAGES*INST_W-1:0]      nxt_inst,
    input  logic [STAGES*DAT_W-1:0]       nxt_dat,
    input  logic                          flush_vld,
    input  logic [$clog2(STAGES)-1:0]     flush_stg,
    output logic [STAGES-1:0]             stg_vld,
    output logic [STAGES*INST_W-1:0]      stg_inst,
    output logic [STAGES*DAT_W-1:0]       stg_dat,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic [$clog2(STAGES+1)-1:0]   occ,
    output logic [CNT_W-1:0]              retire_cnt,
    output logic [CNT_W-1:0]              stall_cnt
);
    localparam int unsigned OCW = $clog2(STAGES + 1);

    logic [STAGES-1:0][INST_W-1:0] w_nxt_inst;
    logic [STAGES-1:0][DAT_W-1:0]  w_nxt_dat;
    logic [STAGES-1:0][INST_W-1:0] r_inst;
    logic [STAGES-1:0][INST_W-1:0] w_src_inst;
    logic [STAGES-1:0][DAT_W-1:0]  r_dat;
    logic [STAGES-1:0][DAT_W-1:0]  w_src_dat;
    logic [STAGES-1:0]             r_vld;
    logic [STAGES-1:0]             w_hold;
    logic [STAGES-1:0]             w_kill;
    logic [STAGES-1:0]             w_load;
    logic [CNT_W-1:0]              r_retire_cnt;
    logic [CNT_W-1:0]              r_stall_cnt;
    logic [31:0]                   w_fstg;
    logic                          w_retire;
    logic                          w_stall_in;
    logic                          w_unused_nxt;

    assign w_nxt_inst = nxt_inst;
    assign w_nxt_dat  = nxt_dat;
    assign w_fstg     = 32'(flush_stg);

    // The last stage's result goes straight to the sink, never into a register here.
    assign w_unused_nxt = ^{w_nxt_inst[STAGES-1], w_nxt_dat[STAGES-1]};

    // A register holds only when it is valid and cannot move; empty regs always absorb upstream.
    always_comb begin : hold_chain
        logic [STAGES-1:0] h;
        h = '0;
        h[STAGES-1] = r_vld[STAGES-1] & (stg_stall[STAGES-1] | ~out_rdy);
        for (int k = STAGES - 2; k >= 0; k--) begin
            h[k] = r_vld[k] & (stg_stall[k] | h[k + 1]);
        end
        w_hold = h;
    end

    always_comb begin
        w_kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_kill[k] = flush_vld & (w_fstg >= 32'(k));
        end
    end

    assign in_rdy     = ~w_hold[0] & ~flush_vld;
    assign out_vld    = r_vld[STAGES-1] & ~stg_stall[STAGES-1];
    assign w_retire   = out_vld & out_rdy;
    assign w_stall_in = in_vld & ~in_rdy;

    // A killed reg must not feed its successor, which turns the reg just above a flush into a bubble.
    always_comb begin
        w_load        = '0;
        w_src_inst    = '0;
        w_src_dat     = '0;
        w_load[0]     = in_vld & in_rdy;
        w_src_inst[0] = in_inst;
        w_src_dat[0]  = in_dat;
        for (int k = 1; k < STAGES; k++) begin
            w_load[k]     = r_vld[k-1] & ~w_hold[k-1] & ~w_kill[k-1];
            w_src_inst[k] = w_nxt_inst[k-1];
            w_src_dat[k]  = w_nxt_dat[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld        <= '0;
            r_inst       <= {STAGES{NOP_INST}};
            r_dat        <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k]  <= 1'b1;
                    r_inst[k] <= w_src_inst[k];
                    r_dat[k]  <= w_src_dat[k];
                end else if (w_kill[k] | ~w_hold[k]) begin
                    r_vld[k]  <= 1'b0;
                    r_inst[k] <= NOP_INST;
                    r_dat[k]  <= '0;
                end
            end
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
            if (w_stall_in) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin : popcount
        logic [OCW-1:0] c;
        c = '0;
        for (int k = 0; k < STAGES; k++) begin
            c = c + OCW'(r_vld[k]);
        end
        occ = c;
    end

    assign stg_vld    = r_vld;
    assign stg_inst   = r_inst;
    assign stg_dat    = r_dat;
    assign retire_cnt = r_retire_cnt;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_etcpu_pipe_ctrl.sv
// Bench for etcpu_pipe_ctrl: directed scenarios plus a randomized run against a token-movement model.
module tb_etcpu_pipe_ctrl;
    localparam int          S   = 4;
    localparam int          IW  = 32;
    localparam int          DW  = 96;
    localparam int          CW  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_vld;
    logic [IW-1:0]   in_inst;
    logic [DW-1:0]   in_dat;
    logic            in_rdy;
    logic [S-1:0]    stg_stall;
    logic [S*IW-1:0] nxt_inst;
    logic [S*DW-1:0] nxt_dat;
    logic            flush_vld;
    logic [1:0]      flush_stg;
    logic [S-1:0]    stg_vld;
    logic [S*IW-1:0] stg_inst;
    logic [S*DW-1:0] stg_dat;
    logic            out_vld;
    logic            out_rdy;
    logic [2:0]      occ;
    logic [CW-1:0]   retire_cnt;
    logic [CW-1:0]   stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    etcpu_pipe_ctrl #(
        .STAGES(S), .INST_W(IW), .DAT_W(DW), .NOP_INST(NOP), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_inst(in_inst), .in_dat(in_dat), .in_rdy(in_rdy),
        .stg_stall(stg_stall), .nxt_inst(nxt_inst), .nxt_dat(nxt_dat),
        .flush_vld(flush_vld), .flush_stg(flush_stg),
        .stg_vld(stg_vld), .stg_inst(stg_inst), .stg_dat(stg_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .occ(occ),
        .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
    );

    // Stage logic is a pass-through, so tokens keep their contents as they move.
    assign nxt_inst = stg_inst;
    assign nxt_dat  = stg_dat;

    always #5 clk = ~clk;

    // Model: each slot holds a token or is empty; tokens advance when the slot ahead is free or moving.
    bit            m_vld [S];
    logic [IW-1:0] m_inst[S];
    logic [DW-1:0] m_dat [S];
    int            m_ret;
    int            m_stl;

    function automatic logic [IW-1:0] inst_of(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    function automatic logic [DW-1:0] dat_of(input int i);
        return {32'hDA7A_0000 + 32'(i), 64'(i * 7 + 1)};
    endfunction

    function automatic logic [IW-1:0] get_inst(input int k);
        return stg_inst[k*IW +: IW];
    endfunction

    function automatic logic [DW-1:0] get_dat(input int k);
        return stg_dat[k*DW +: DW];
    endfunction

    function automatic logic [S-1:0] m_moves();
        logic [S-1:0] mv;
        mv[S-1] = m_vld[S-1] && !stg_stall[S-1] && out_rdy;
        for (int k = S - 2; k >= 0; k--)
            mv[k] = m_vld[k] && !stg_stall[k] && (!m_vld[k+1] || mv[k+1]);
        return mv;
    endfunction

    function automatic logic m_in_rdy();
        logic [S-1:0] mv;
        mv = m_moves();
        return !flush_vld && (!m_vld[0] || mv[0]);
    endfunction

    function automatic int m_occ();
        int c;
        c = 0;
        for (int k = 0; k < S; k++) c += int'(m_vld[k]);
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            m_vld[k] = 1'b0; m_inst[k] = NOP; m_dat[k] = '0;
        end
        m_ret = 0;
        m_stl = 0;
    endtask

    task automatic model_advance();
        logic [S-1:0]  mv;
        bit            acc;
        int            f;
        bit            nv[S];
        logic [IW-1:0] ni[S];
        logic [DW-1:0] nd[S];
        mv  = m_moves();
        acc = in_vld && m_in_rdy();
        if (mv[S-1]) m_ret = (m_ret + 1) % (1 << CW);
        if (in_vld && !acc) m_stl = (m_stl + 1) % (1 << CW);
        f = flush_vld ? int'(flush_stg) : -1;
        for (int k = 0; k < S; k++) begin
            nv[k] = 1'b0; ni[k] = NOP; nd[k] = '0;
        end
        for (int k = 0; k < S; k++) begin
            if (m_vld[k] && k > f) begin
                int d;
                d = mv[k] ? k + 1 : k;
                if (d < S) begin
                    nv[d] = 1'b1; ni[d] = m_inst[k]; nd[d] = m_dat[k];
                end
            end
        end
        if (acc) begin
            nv[0] = 1'b1; ni[0] = in_inst; nd[0] = in_dat;
        end
        m_vld  = nv;
        m_inst = ni;
        m_dat  = nd;
    endtask

    task automatic clk_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_vld = 1'b0; in_inst = '0; in_dat = '0; stg_stall = '0;
        flush_vld = 1'b0; flush_stg = '0; out_rdy = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_pipe();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < S; i++) begin
            in_vld = 1'b1; in_inst = inst_of(i); in_dat = dat_of(i);
            clk_cycle();
        end
        in_vld = 1'b0;
    endtask

    task automatic test_reset();
        logic [S*IW-1:0] nopv;
        nopv = {S{NOP}};
        do_reset();
        n_chk++;
        if (stg_vld !== 4'b0000 || occ !== 3'd0 || out_vld !== 1'b0) begin
            n_fail++; $display("FAIL reset_vld: vld=%b occ=%0d out_vld=%b want 0", stg_vld, occ, out_vld);
        end
        n_chk++;
        if (stg_inst !== nopv || stg_dat !== '0) begin
            n_fail++; $display("FAIL reset_regs: inst=%h dat0=%h want NOP/0", stg_inst, get_dat(0));
        end
        n_chk++;
        if (retire_cnt !== 4'd0 || stall_cnt !== 4'd0 || in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL reset_cnt: ret=%0d stl=%0d in_rdy=%b want 0 0 1", retire_cnt, stall_cnt, in_rdy);
        end
    endtask

    task automatic test_stream();
        int seen;
        int nret;
        seen = -1;
        nret = 0;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            if (e <= 4) begin
                in_vld = 1'b1; in_inst = inst_of(10 + e - 1); in_dat = dat_of(10 + e - 1);
            end else in_vld = 1'b0;
            #1;
            if (out_vld && out_rdy) begin
                n_chk++;
                if (get_inst(S-1) !== inst_of(10 + nret)) begin
                    n_fail++; $display("FAIL stream_order: got %h want %h", get_inst(S-1), inst_of(10 + nret));
                end
                nret++;
            end
            clk_cycle();
            if (seen < 0 && out_vld && get_inst(S-1) === inst_of(10)) seen = e;
        end
        n_chk++;
        if (seen !== 4) begin
            n_fail++; $display("FAIL stream_latency: out_vld at edge %0d want 4", seen);
        end
        n_chk++;
        if (retire_cnt !== 4'd4 || occ !== 3'd0 || nret !== 4) begin
            n_fail++; $display("FAIL stream_done: ret=%0d occ=%0d seen=%0d want 4 0 4", retire_cnt, occ, nret);
        end
    endtask

    task automatic test_stall();
        logic [S-1:0] ev;
        fill_pipe();
        out_rdy = 1'b1; stg_stall = 4'b0010;
        in_vld = 1'b1; in_inst = inst_of(4); in_dat = dat_of(4);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_chk++;
            if (in_rdy !== 1'b0) begin
                n_fail++; $display("FAIL stall_in_rdy: got %b want 0", in_rdy);
            end
            clk_cycle();
            ev = (c == 0) ? 4'b1011 : 4'b0011;
            n_chk++;
            if (stg_vld !== ev || get_inst(2) !== NOP || get_inst(1) !== inst_of(2) || get_inst(0) !== inst_of(3)) begin
                n_fail++; $display("FAIL stall_regs: vld=%b i2=%h i1=%h i0=%h want %b", stg_vld, get_inst(2), get_inst(1), get_inst(0), ev);
            end
        end
        n_chk++;
        if (stall_cnt !== 4'd2) begin
            n_fail++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt);
        end
        idle();
    endtask

    task automatic test_outrdy_hole();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_inst = inst_of(i); in_dat = dat_of(i);
            clk_cycle();
        end
        in_vld = 1'b0;
        clk_cycle();
        in_vld = 1'b1; in_inst = inst_of(3); in_dat = dat_of(3);
        #1;
        n_chk++;
        if (stg_vld !== 4'b1110 || in_rdy !== 1'b1) begin
            n_fail++; $display("FAIL hole_pre: vld=%b in_rdy=%b want 1110 1", stg_vld, in_rdy);
        end
        clk_cycle();
        in_vld = 1'b0;
        n_chk++;
        if (stg_vld !== 4'b1111 || occ !== 3'd4 || get_inst(3) !== inst_of(0) || get_inst(2) !== inst_of(1)
            || get_inst(1) !== inst_of(2) || get_inst(0) !== inst_of(3) || get_dat(0) !== dat_of(3)) begin
            n_fail++; $display("FAIL hole_post: vld=%b occ=%0d i3..0=%h %h %h %h", stg_vld, occ, get_inst(3), get_inst(2), get_inst(1), get_inst(0));
        end
        idle();
    endtask

    task automatic test_flush_partial();
        fill_pipe();
        flush_vld = 1'b1; flush_stg = 2'd1;
        in_vld = 1'b1; in_inst = inst_of(99); in_dat = dat_of(99);
        #1;
        n_chk++;
        if (in_rdy !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_rdy: got %b want 0", in_rdy);
        end
        clk_cycle();
        flush_vld = 1'b0; in_vld = 1'b0;
        n_chk++;
        if (stg_vld !== 4'b1100 || occ !== 3'd2 || get_inst(0) !== NOP || get_inst(1) !== NOP || get_dat(1) !== '0
            || get_inst(2) !== inst_of(1) || get_inst(3) !== inst_of(0)) begin
            n_fail++; $display("FAIL flush_regs: vld=%b occ=%0d i1=%h i0=%h want 1100 2", stg_vld, occ, get_inst(1), get_inst(0));
        end
        n_chk++;
        if (stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL flush_stall_cnt: got %0d want 1", stall_cnt);
        end
        clk_cycle();
        n_chk++;
        if (stg_vld !== 4'b1100) begin
            n_fail++; $display("FAIL flush_dropped: vld=%b want 1100", stg_vld);
        end
        idle();
    endtask

    task automatic test_flush_all();
        fill_pipe();
        out_rdy = 1'b1; stg_stall = 4'b1000; flush_vld = 1'b1; flush_stg = 2'd3;
        #1;
        n_chk++;
        if (out_vld !== 1'b0) begin
            n_fail++; $display("FAIL flushall_out_vld: got %b want 0", out_vld);
        end
        clk_cycle();
        idle();
        n_chk++;
        if (stg_vld !== 4'b0000 || retire_cnt !== 4'd0 || occ !== 3'd0) begin
            n_fail++; $display("FAIL flushall_stall: vld=%b ret=%0d occ=%0d want 0 0 0", stg_vld, retire_cnt, occ);
        end
        fill_pipe();
        out_rdy = 1'b1; flush_vld = 1'b1; flush_stg = 2'd3;
        clk_cycle();
        idle();
        n_chk++;
        if (stg_vld !== 4'b0000 || retire_cnt !== 4'd1) begin
            n_fail++; $display("FAIL flushall_retire: vld=%b ret=%0d want 0 1", stg_vld, retire_cnt);
        end
    endtask

    task automatic test_cnt_wrap();
        int fed;
        fed = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            if (fed < 17) begin
                in_vld = 1'b1; in_inst = inst_of(fed); in_dat = dat_of(fed);
            end else in_vld = 1'b0;
            #1;
            if (in_vld && in_rdy) fed++;
            clk_cycle();
        end
        idle();
        n_chk++;
        if (retire_cnt !== 4'd1 || occ !== 3'd0 || fed !== 17) begin
            n_fail++; $display("FAIL cnt_wrap: ret=%0d occ=%0d fed=%0d want 1 0 17", retire_cnt, occ, fed);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1; in_inst = inst_of(i); in_dat = dat_of(i);
            clk_cycle();
        end
        n_chk++;
        if (stg_vld !== 4'b0111) begin
            n_fail++; $display("FAIL arst_pre: vld=%b want 0111", stg_vld);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (stg_vld !== 4'b0000 || occ !== 3'd0 || get_inst(0) !== NOP) begin
            n_fail++; $display("FAIL arst_async: vld=%b occ=%0d i0=%h want 0 0 NOP", stg_vld, occ, get_inst(0));
        end
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int e_occ;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_inst = $urandom;
            in_dat  = {$urandom, $urandom, $urandom};
            for (int k = 0; k < S; k++) stg_stall[k] = ($urandom_range(0, 5) == 0);
            out_rdy   = ($urandom_range(0, 3) != 0);
            flush_vld = ($urandom_range(0, 11) == 0);
            flush_stg = 2'($urandom_range(0, 3));
            #1;
            e_occ = m_occ();
            n_chk++;
            if (in_rdy !== m_in_rdy() || out_vld !== (m_vld[S-1] && !stg_stall[S-1]) || occ !== 3'(e_occ)) begin
                n_fail++; $display("FAIL rand_comb c=%0d: in_rdy=%b out_vld=%b occ=%0d want %b %b %0d",
                    c, in_rdy, out_vld, occ, m_in_rdy(), m_vld[S-1] && !stg_stall[S-1], e_occ);
            end
            clk_cycle();
            for (int k = 0; k < S; k++) begin
                n_chk++;
                if (stg_vld[k] !== m_vld[k] || get_inst(k) !== m_inst[k] || get_dat(k) !== m_dat[k]) begin
                    n_fail++; $display("FAIL rand_reg c=%0d k=%0d: vld=%b inst=%h want %b %h",
                        c, k, stg_vld[k], get_inst(k), m_vld[k], m_inst[k]);
                end
            end
            n_chk++;
            if (retire_cnt !== CW'(m_ret) || stall_cnt !== CW'(m_stl)) begin
                n_fail++; $display("FAIL rand_cnt c=%0d: ret=%0d stl=%0d want %0d %0d", c, retire_cnt, stall_cnt, m_ret, m_stl);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_outrdy_hole();
        test_flush_partial();
        test_flush_all();
        test_cnt_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
